// File: rtl/sao_apply.sv
// SAO apply engine: classifies each pixel of a window (edge offset or band
// offset) in stage 1, then adds the selected offset and clips in stage 2.
// One parameter set is latched per CTU and stays fixed until the CTU drains.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a CTU parameter handshake; param_ready high
// ACTIVE | accepting windows until the in_last handshake
// DRAIN  | no new windows; waiting for the last window to leave stage 2
module sao_apply #(
   parameter int bit_depth         = 8,
   parameter int org_window_width  = 4,
   parameter int org_window_height = 2,
   parameter int offset_len        = 4,
   parameter int n_category        = 4
) (
   input  logic                                   clk,
   input  logic                                   arst_n,
   input  logic                                   param_valid,
   output logic                                   param_ready,
   input  logic [2:0]                             sao_type_i,
   input  logic [n_category-1:0][offset_len-1:0]  offset_i,
   input  logic [4:0]                             band_pos_i,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic                                   in_last,
   input  logic [3:0]                             edge_i,
   input  logic [org_window_height+1:0][org_window_width+1:0][bit_depth-1:0] rec_in,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic                                   out_last,
   output logic [org_window_width*org_window_height-1:0][bit_depth-1:0] sao_out,
   output logic                                   busy
);

   localparam int W  = org_window_width;
   localparam int H  = org_window_height;
   localparam int NP = W * H;

   localparam logic [1:0] st_idle   = 2'd0;
   localparam logic [1:0] st_active = 2'd1;
   localparam logic [1:0] st_drain  = 2'd2;

   logic [1:0]                            state;
   logic [1:0]                            state_nxt;
   logic [2:0]                            type_q;
   logic [n_category-1:0][offset_len-1:0] off_q;
   logic [4:0]                            band_pos_q;

   logic                                  s1_valid;
   logic                                  s1_last;
   logic [NP-1:0][bit_depth-1:0]          s1_pix;
   logic [NP-1:0][1:0]                    s1_cat;
   logic [NP-1:0]                         s1_hit;

   logic [NP-1:0][bit_depth-1:0]          pix_d;
   logic [NP-1:0][1:0]                    cat_d;
   logic [NP-1:0]                         hit_d;
   logic [NP-1:0][bit_depth-1:0]          res_d;

   logic in_fire, out_fire, s1_ready, s2_ready;
   logic is_eo, is_bo;
   logic [1:0] eo_cls;

   assign s2_ready    = !out_valid || out_ready;
   assign s1_ready    = !s1_valid || s2_ready;
   assign in_ready    = (state == st_active) && s1_ready;
   assign in_fire     = in_valid && in_ready;
   assign out_fire    = out_valid && out_ready;
   assign param_ready = (state == st_idle);
   assign busy        = (state != st_idle);

   // types 1..4 are EO classes 0..3; 5 is BO; 0, 6, 7 leave pixels alone
   assign is_eo  = (type_q >= 3'd1) && (type_q <= 3'd4);
   assign is_bo  = (type_q == 3'd5);
   assign eo_cls = type_q[1:0] - 2'd1;

   for (genvar r = 0; r < H; r++) begin : g_row
      for (genvar c = 0; c < W; c++) begin : g_col
         localparam int   p         = r * W + c;
         localparam logic top_row   = (r == 0);
         localparam logic bot_row   = (r == H - 1);
         localparam logic left_col  = (c == 0);
         localparam logic right_col = (c == W - 1);

         logic [3:0][bit_depth-1:0] na;
         logic [3:0][bit_depth-1:0] nb;
         logic [3:0]                blk;
         logic [bit_depth-1:0]      cen, a, b;
         logic signed [2:0]         sa, sb, s;
         logic [4:0]                k;
         logic [1:0]                cat;
         logic                      hit;
         logic [bit_depth+1:0]      off_ext, sum;
         logic [bit_depth-1:0]      res;

         // neighbour pairs per EO class in padded-window coordinates
         assign cen   = rec_in[r+1][c+1];
         assign na[0] = rec_in[r+1][c];
         assign nb[0] = rec_in[r+1][c+2];
         assign na[1] = rec_in[r][c+1];
         assign nb[1] = rec_in[r+2][c+1];
         assign na[2] = rec_in[r][c];
         assign nb[2] = rec_in[r+2][c+2];
         assign na[3] = rec_in[r][c+2];
         assign nb[3] = rec_in[r+2][c];

         // a neighbour outside the picture disables EO for this pixel;
         // diagonal neighbours are lost if either their row or column is out
         assign blk[0] = (left_col & edge_i[3]) | (right_col & edge_i[2]);
         assign blk[1] = (top_row & edge_i[1]) | (bot_row & edge_i[0]);
         assign blk[2] = (top_row & edge_i[1]) | (left_col & edge_i[3]) |
                         (bot_row & edge_i[0]) | (right_col & edge_i[2]);
         assign blk[3] = (top_row & edge_i[1]) | (right_col & edge_i[2]) |
                         (bot_row & edge_i[0]) | (left_col & edge_i[3]);

         // stage-1 classification: category index and whether to apply it
         always_comb begin
            a   = na[eo_cls];
            b   = nb[eo_cls];
            sa  = (cen > a) ? 3'sd1 : ((cen < a) ? -3'sd1 : 3'sd0);
            sb  = (cen > b) ? 3'sd1 : ((cen < b) ? -3'sd1 : 3'sd0);
            s   = sa + sb;
            k   = cen[bit_depth-1 -: 5] - band_pos_q;
            cat = 2'd0;
            hit = 1'b0;
            if (is_eo && !blk[eo_cls]) begin
               case (s)
                  -3'sd2:  begin cat = 2'd0; hit = 1'b1; end
                  -3'sd1:  begin cat = 2'd1; hit = 1'b1; end
                  3'sd1:   begin cat = 2'd2; hit = 1'b1; end
                  3'sd2:   begin cat = 2'd3; hit = 1'b1; end
                  default: begin cat = 2'd0; hit = 1'b0; end
               endcase
            end else if (is_bo && (k < 5'd4)) begin
               cat = k[1:0];
               hit = 1'b1;
            end
         end

         assign pix_d[p] = cen;
         assign cat_d[p] = cat;
         assign hit_d[p] = hit;

         // stage-2 offset add in bit_depth+2 bits, then clip to the sample range
         always_comb begin
            off_ext = {{(bit_depth + 2 - offset_len){off_q[s1_cat[p]][offset_len-1]}},
                       off_q[s1_cat[p]]};
            sum     = {2'b00, s1_pix[p]} + (s1_hit[p] ? off_ext : '0);
            if (sum[bit_depth+1])
               res = '0;
            else if (sum[bit_depth])
               res = '1;
            else
               res = sum[bit_depth-1:0];
         end

         assign res_d[p] = res;
      end
   end

   // CTU sequencing: one parameter set per CTU, drain before the next
   always_comb begin
      state_nxt = state;
      case (state)
         st_idle:   if (param_valid)          state_nxt = st_active;
         st_active: if (in_fire && in_last)   state_nxt = st_drain;
         st_drain:  if (out_fire && out_last) state_nxt = st_idle;
         default:                             state_nxt = st_idle;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= st_idle;
      else         state <= state_nxt;
   end

   // CTU parameters, captured only on the IDLE handshake
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         type_q     <= '0;
         off_q      <= '0;
         band_pos_q <= '0;
      end else if ((state == st_idle) && param_valid) begin
         type_q     <= sao_type_i;
         off_q      <= offset_i;
         band_pos_q <= band_pos_i;
      end
   end

   // stage 1 register: centre pixels with their category decisions
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_pix   <= '0;
         s1_cat   <= '0;
         s1_hit   <= '0;
      end else if (s1_ready) begin
         s1_valid <= in_fire;
         if (in_fire) begin
            s1_pix  <= pix_d;
            s1_cat  <= cat_d;
            s1_hit  <= hit_d;
            s1_last <= in_last;
         end
      end
   end

   // stage 2 register doubles as the output; it holds while downstream stalls
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         sao_out   <= '0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sao_out  <= res_d;
            out_last <= s1_last;
         end
      end
   end

endmodule

// File: tb/tb_sao_apply.sv
// Randomised scoreboard bench for sao_apply. Expected windows come from an
// integer reference model of the SAO rules and are queued at the input
// handshake; a monitor pops and compares whenever an output is accepted.
module tb_sao_apply;

   localparam int BD = 8;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int NP = W * H;
   localparam int OL = 4;
   localparam int NC = 4;

   typedef logic [H+1:0][W+1:0][BD-1:0] win_t;
   typedef logic [NP-1:0][BD-1:0]       pix_t;
   typedef struct {
      pix_t data;
      logic last;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   arst_n;
   logic                   param_valid;
   logic                   param_ready;
   logic [2:0]             sao_type_i;
   logic [NC-1:0][OL-1:0]  offset_i;
   logic [4:0]             band_pos_i;
   logic                   in_valid;
   logic                   in_ready;
   logic                   in_last;
   logic [3:0]             edge_i;
   win_t                   rec_in;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;
   pix_t                   sao_out;
   logic                   busy;

   sao_apply #(
      .bit_depth(BD), .org_window_width(W), .org_window_height(H),
      .offset_len(OL), .n_category(NC)
   ) dut (
      .clk(clk), .arst_n(arst_n),
      .param_valid(param_valid), .param_ready(param_ready),
      .sao_type_i(sao_type_i), .offset_i(offset_i), .band_pos_i(band_pos_i),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .edge_i(edge_i), .rec_in(rec_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .sao_out(sao_out), .busy(busy)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   int   cur_type = 0;
   int   cur_bpos = 0;
   int   cur_off[4] = '{0, 0, 0, 0};
   int   rmode = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   function automatic int sgn(input int x);
      return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
   endfunction

   function automatic bit outside(input int rr, input int cc, input logic [3:0] e);
      return (cc == 0 && e[3]) || (cc == W + 1 && e[2]) ||
             (rr == 0 && e[1]) || (rr == H + 1 && e[0]);
   endfunction

   // Reference: plain integer arithmetic over the padded window
   function automatic pix_t model(input win_t w, input logic [3:0] e);
      pix_t o;
      int dr, dc, rr, cc, pix, v, ar, ac, br, bc, s, k;
      dr = 0; dc = 0;
      case (cur_type)
         1: begin dr = 0; dc = 1;  end
         2: begin dr = 1; dc = 0;  end
         3: begin dr = 1; dc = 1;  end
         4: begin dr = 1; dc = -1; end
         default: begin dr = 0; dc = 0; end
      endcase
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            rr  = r + 1;
            cc  = c + 1;
            pix = int'(w[rr][cc]);
            v   = pix;
            if (cur_type >= 1 && cur_type <= 4) begin
               ar = rr - dr; ac = cc - dc;
               br = rr + dr; bc = cc + dc;
               if (!outside(ar, ac, e) && !outside(br, bc, e)) begin
                  s = sgn(pix - int'(w[ar][ac])) + sgn(pix - int'(w[br][bc]));
                  case (s)
                     -2: v = pix + cur_off[0];
                     -1: v = pix + cur_off[1];
                     1:  v = pix + cur_off[2];
                     2:  v = pix + cur_off[3];
                     default: v = pix;
                  endcase
               end
            end else if (cur_type == 5) begin
               k = ((pix >> (BD - 5)) - cur_bpos + 32) % 32;
               if (k < 4) v = pix + cur_off[k];
            end
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
            o[r*W+c] = BD'(v);
         end
      end
      return o;
   endfunction

   function automatic win_t rand_win();
      win_t w;
      int   m;
      m = $urandom_range(0, 2);
      for (int r = 0; r < H + 2; r++) begin
         for (int c = 0; c < W + 2; c++) begin
            case (m)
               0: w[r][c] = BD'($urandom_range(100, 102));
               1: w[r][c] = BD'($urandom_range(0, 255));
               default: w[r][c] = ($urandom_range(0, 1) != 0) ? BD'($urandom_range(248, 255))
                                                              : BD'($urandom_range(0, 7));
            endcase
         end
      end
      return w;
   endfunction

   function automatic int rand_off();
      return int'($urandom_range(0, 15)) - 8;
   endfunction

   // Offer one parameter set; optionally keep param_valid high with junk afterwards
   task automatic do_param(input int typ, input int o0, input int o1, input int o2,
                           input int o3, input int bp, input bit keep);
      bit ok;
      cur_type = typ;
      cur_off  = '{o0, o1, o2, o3};
      cur_bpos = bp;
      sao_type_i = 3'(typ);
      for (int k = 0; k < NC; k++) offset_i[k] = OL'(cur_off[k]);
      band_pos_i  = 5'(bp);
      param_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (param_ready) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL param_handshake: actual timeout required param_ready");
      end
      @(posedge clk); #1;
      if (keep) begin
         sao_type_i = 3'($urandom_range(0, 7));
         offset_i   = 16'($urandom);
         band_pos_i = 5'($urandom);
      end else begin
         param_valid = 1'b0;
      end
   endtask

   task automatic send_win(input win_t w, input logic [3:0] e, input logic last);
      bit   ok;
      exp_t x;
      rec_in   = w;
      edge_i   = e;
      in_last  = last;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok     = 1'b1;
            x.data = model(w, e);
            x.last = last;
            exp_q.push_back(x);
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL in_handshake: actual timeout required in_ready");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual busy=%0d pending=%0d required idle and empty",
                  name, busy, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   // downstream ready pattern: 0 always, 1 toggle, 2 random, 3 stalled
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // monitor: stall stability and in-order scoreboard comparison
   initial begin : monitor
      bit   held;
      pix_t hold_data;
      logic hold_last;
      exp_t x;
      held = 1'b0;
      hold_data = '0;
      hold_last = 1'b0;
      forever begin
         @(negedge clk);
         if (!arst_n) begin
            held = 1'b0;
         end else begin
            if (held)
               check("stall_hold", {out_valid, out_last, sao_out}, {1'b1, hold_last, hold_data});
            if (out_valid && out_ready) begin
               held = 1'b0;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: actual %h required no output", sao_out);
               end else begin
                  x = exp_q.pop_front();
                  check("window", {out_last, sao_out}, {x.last, x.data});
               end
            end else if (out_valid) begin
               held      = 1'b1;
               hold_data = sao_out;
               hold_last = out_last;
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: actual time limit reached required completion");
      $fatal(1, "watchdog expired");
   end

   win_t w, w_eo;
   int   row1[6] = '{10, 5, 10, 7, 7, 7};
   int   row2[6] = '{2, 5, 2, 2, 2, 2};
   int   px[8];
   int   nwin;

   initial begin
      arst_n      = 1'b0;
      param_valid = 1'b0;
      sao_type_i  = '0;
      offset_i    = '0;
      band_pos_i  = '0;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      edge_i      = '0;
      rec_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid",   out_valid,   1'b0);
      check("rst_out_last",    out_last,    1'b0);
      check("rst_sao_out",     sao_out,     64'h0);
      check("rst_busy",        busy,        1'b0);
      check("rst_in_ready",    in_ready,    1'b0);
      check("rst_param_ready", param_ready, 1'b1);
      #2 arst_n = 1'b1;
      @(posedge clk); #1;

      // EO class 0 with the quoted rows; also pins the 2-cycle latency
      w_eo = '0;
      for (int c = 0; c < W + 2; c++) begin
         w_eo[1][c] = BD'(row1[c]);
         w_eo[2][c] = BD'(row2[c]);
      end
      do_param(1, 3, 1, -1, -4, 0, 0);
      send_win(w_eo, 4'b0000, 1'b1);
      @(negedge clk);
      check("latency_cycle1", out_valid, 1'b0);
      @(negedge clk);
      check("latency_cycle2", out_valid, 1'b1);
      wait_idle("drain_eo0");

      // BO with band position wrapping past 31
      px = '{245, 3, 12, 100, 8, 16, 255, 0};
      do_param(5, 2, -2, 4, -4, 30, 0);
      w = rand_win();
      for (int p = 0; p < NP; p++) w[p/W+1][p%W+1] = BD'(px[p]);
      send_win(w, 4'b0000, 1'b0);
      send_win(rand_win(), 4'b0000, 1'b1);
      wait_idle("drain_bo30");

      // BO clipping at both ends
      px = '{250, 255, 0, 5, 8, 16, 248, 100};
      do_param(5, 7, -8, 3, -3, 31, 0);
      w = rand_win();
      for (int p = 0; p < NP; p++) w[p/W+1][p%W+1] = BD'(px[p]);
      send_win(w, 4'b0000, 1'b1);
      wait_idle("drain_bo_clip");

      // EO class 1 with top edge, then all and no edges
      do_param(2, rand_off(), rand_off(), rand_off(), rand_off(), 0, 0);
      send_win(rand_win(), 4'b0010, 1'b0);
      send_win(rand_win(), 4'b1111, 1'b0);
      send_win(rand_win(), 4'b0000, 1'b1);
      wait_idle("drain_eo1");

      // diagonal classes with corner edges, then OFF types
      for (int t = 3; t <= 4; t++) begin
         do_param(t, rand_off(), rand_off(), rand_off(), rand_off(), 0, 0);
         send_win(rand_win(), 4'b1010, 1'b0);
         send_win(rand_win(), 4'b0101, 1'b0);
         send_win(rand_win(), 4'($urandom_range(0, 15)), 1'b1);
         wait_idle("drain_eo_diag");
      end
      for (int t = 0; t < 3; t++) begin
         do_param((t == 0) ? 0 : t + 5, rand_off(), rand_off(), rand_off(), rand_off(), 3, 0);
         send_win(rand_win(), 4'($urandom_range(0, 15)), 1'b1);
         wait_idle("drain_off");
      end

      // parameters offered mid-CTU must be ignored
      do_param(5, 3, -3, 5, -5, 12, 1);
      send_win(rand_win(), 4'b0000, 1'b0);
      check("param_ready_busy", param_ready, 1'b0);
      send_win(rand_win(), 4'b0000, 1'b0);
      send_win(rand_win(), 4'b0000, 1'b1);
      param_valid = 1'b0;
      wait_idle("drain_param_hold");

      // five-window stream under alternating backpressure
      rmode = 1;
      do_param(int'($urandom_range(1, 5)), rand_off(), rand_off(), rand_off(), rand_off(),
               int'($urandom_range(0, 31)), 0);
      for (int i = 0; i < 5; i++) send_win(rand_win(), 4'($urandom_range(0, 15)), 1'(i == 4));
      wait_idle("drain_stream5");
      check("stream5_busy", busy, 1'b0);
      rmode = 0;

      // reset with two windows in flight, then a fresh CTU
      rmode = 3;
      do_param(1, 3, 1, -1, -4, 0, 0);
      send_win(rand_win(), 4'b0000, 1'b0);
      send_win(rand_win(), 4'b0000, 1'b0);
      #3 arst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy",      busy,      1'b0);
      check("midrst_sao_out",   sao_out,   64'h0);
      exp_q.delete();
      rmode = 0;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("postrst_out_valid", out_valid, 1'b0);
      check("postrst_in_ready",  in_ready,  1'b0);
      do_param(1, 3, 1, -1, -4, 0, 0);
      send_win(w_eo, 4'b0000, 1'b1);
      wait_idle("drain_after_reset");

      // randomised CTUs
      for (int n = 0; n < 25; n++) begin
         rmode = $urandom_range(0, 2);
         do_param(int'($urandom_range(0, 7)), rand_off(), rand_off(), rand_off(), rand_off(),
                  int'($urandom_range(0, 31)), 0);
         nwin = $urandom_range(1, 5);
         for (int i = 0; i < nwin; i++) begin
            send_win(rand_win(), 4'($urandom_range(0, 15)), 1'(i == nwin - 1));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk); #1;
            end
         end
         wait_idle("drain_random");
      end
      rmode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
